upsizer_aw_arbiter: RTL and testbench

// Shares the single write path of the upsizer between NUM_M AXI masters.
// - Round-robin arbitration on the AW channel.
// - The granted master owns the W channel until its WLAST beat.
// - B responses return to the issuing master, in AW order, through an internal index FIFO.
// - Sits between the wide masters and the upsizer master-side write ports.

---
 rtl/upsizer_aw_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_upsizer_aw_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsizer_aw_arbiter.sv
// Round-robin write-path arbiter in front of the upsizer: AW grant, W ownership until WLAST,
// and in-order B routing back to the issuing master through a small index FIFO.
//
// state   | meaning
// IDLE    | no grant; pick next requester when the B-routing FIFO has room
// AW      | present granted master's AW to the upsizer, wait for handshake
// W       | granted master owns the W channel until its WLAST handshake
module upsizer_aw_arbiter #(
    parameter int NUM_M       = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int ID_WIDTH    = 3,
    parameter int DATA_WIDTH  = 128,
    parameter int OUTSTANDING = 4
) (
    input  logic                        aclk,
    input  logic                        arst_n,
    input  logic [NUM_M-1:0]            m_awvalid_i,
    input  logic [NUM_M*ADDR_WIDTH-1:0] m_awaddr_i,
    input  logic [NUM_M*LEN_WIDTH-1:0]  m_awlen_i,
    input  logic [NUM_M*3-1:0]          m_awsize_i,
    input  logic [NUM_M*2-1:0]          m_awburst_i,
    input  logic [NUM_M*ID_WIDTH-1:0]   m_awid_i,
    output logic [NUM_M-1:0]            m_awready_o,
    input  logic [NUM_M*DATA_WIDTH-1:0] m_wdata_i,
    input  logic [NUM_M-1:0]            m_wvalid_i,
    input  logic [NUM_M-1:0]            m_wlast_i,
    output logic [NUM_M-1:0]            m_wready_o,
    output logic [NUM_M-1:0]            m_bvalid_o,
    output logic [ID_WIDTH-1:0]         m_bid_o,
    output logic [1:0]                  m_bresp_o,
    input  logic [NUM_M-1:0]            m_bready_i,
    output logic [ADDR_WIDTH-1:0]       s_awaddr_o,
    output logic [LEN_WIDTH-1:0]        s_awlen_o,
    output logic [2:0]                  s_awsize_o,
    output logic [1:0]                  s_awburst_o,
    output logic [ID_WIDTH-1:0]         s_awid_o,
    output logic                        s_awvalid_o,
    input  logic                        s_awready_i,
    output logic [DATA_WIDTH-1:0]       s_wdata_o,
    output logic                        s_wvalid_o,
    output logic                        s_wlast_o,
    input  logic                        s_wready_i,
    input  logic                        s_bvalid_i,
    input  logic [ID_WIDTH-1:0]         s_bid_i,
    input  logic [1:0]                  s_bresp_i,
    output logic                        s_bready_o
);

    localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   grant, grant_nxt;
    logic [GW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [GW:0]     cand;
    logic            found;

    logic [GW-1:0]   fifo_mem [OUTSTANDING];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            fifo_full, fifo_empty;
    logic            push, pop;
    logic [GW-1:0]   head;
    logic            w_last_hs;

    assign fifo_full  = (count == CW'(OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];
    assign push       = (state == ST_AW) && s_awready_i;
    assign pop        = s_bvalid_i && s_bready_o;
    assign w_last_hs  = (state == ST_W) && s_wvalid_o && s_wready_i && s_wlast_o;

    assign m_bid_o   = s_bid_i;
    assign m_bresp_o = s_bresp_i;

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        found      = 1'b0;
        cand       = '0;
        case (state)
            ST_IDLE: begin
                if (|m_awvalid_i && !fifo_full) begin
                    // scan cyclically starting at the round-robin pointer
                    for (int i = 0; i < NUM_M; i++) begin
                        cand = {1'b0, rr_ptr} + (GW+1)'(i);
                        if (cand >= (GW+1)'(NUM_M)) begin
                            cand = cand - (GW+1)'(NUM_M);
                        end
                        if (!found && m_awvalid_i[cand[GW-1:0]]) begin
                            found     = 1'b1;
                            grant_nxt = cand[GW-1:0];
                        end
                    end
                    state_nxt = ST_AW;
                end
            end
            ST_AW: begin
                if (s_awready_i) begin
                    state_nxt = ST_W;
                end
            end
            ST_W: begin
                if (w_last_hs) begin
                    rr_ptr_nxt = (grant == GW'(NUM_M - 1)) ? '0 : grant + GW'(1);
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_awvalid_o = 1'b0;
        s_awaddr_o  = '0;
        s_awlen_o   = '0;
        s_awsize_o  = '0;
        s_awburst_o = '0;
        s_awid_o    = '0;
        m_awready_o = '0;
        s_wvalid_o  = 1'b0;
        s_wdata_o   = '0;
        s_wlast_o   = 1'b0;
        m_wready_o  = '0;
        if (state == ST_AW) begin
            s_awvalid_o        = 1'b1;
            s_awaddr_o         = m_awaddr_i[grant*ADDR_WIDTH +: ADDR_WIDTH];
            s_awlen_o          = m_awlen_i[grant*LEN_WIDTH +: LEN_WIDTH];
            s_awsize_o         = m_awsize_i[grant*3 +: 3];
            s_awburst_o        = m_awburst_i[grant*2 +: 2];
            s_awid_o           = m_awid_i[grant*ID_WIDTH +: ID_WIDTH];
            m_awready_o[grant] = s_awready_i;
        end
        if (state == ST_W) begin
            s_wvalid_o        = m_wvalid_i[grant];
            s_wdata_o         = m_wdata_i[grant*DATA_WIDTH +: DATA_WIDTH];
            s_wlast_o         = m_wlast_i[grant];
            m_wready_o[grant] = s_wready_i;
        end
    end

    always_comb begin
        m_bvalid_o = '0;
        s_bready_o = 1'b0;
        if (!fifo_empty) begin
            m_bvalid_o[head] = s_bvalid_i;
            s_bready_o       = m_bready_i[head];
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(OUTSTANDING - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(OUTSTANDING - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // entries are only read while the count says they are valid, so no reset is needed
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= grant;
        end
    end

endmodule

// File: tb/tb_upsizer_aw_arbiter.sv
// Randomized scoreboard bench for upsizer_aw_arbiter: masters/slave models drive traffic,
// a monitor predicts grants, W ownership and B routing from arbitration rules.
module tb_upsizer_aw_arbiter;

    localparam int NM  = 2;
    localparam int OUT = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [2:0]  id;
    } aw_t;

    logic              aclk = 1'b0;
    logic              arst_n;
    logic [NM-1:0]     m_awvalid_i = '0;
    logic [NM*32-1:0]  m_awaddr_i = '0;
    logic [NM*8-1:0]   m_awlen_i = '0;
    logic [NM*3-1:0]   m_awsize_i = '0;
    logic [NM*2-1:0]   m_awburst_i = '0;
    logic [NM*3-1:0]   m_awid_i = '0;
    logic [NM-1:0]     m_awready_o;
    logic [NM*128-1:0] m_wdata_i = '0;
    logic [NM-1:0]     m_wvalid_i = '0;
    logic [NM-1:0]     m_wlast_i = '0;
    logic [NM-1:0]     m_wready_o;
    logic [NM-1:0]     m_bvalid_o;
    logic [2:0]        m_bid_o;
    logic [1:0]        m_bresp_o;
    logic [NM-1:0]     m_bready_i = '0;
    logic [31:0]       s_awaddr_o;
    logic [7:0]        s_awlen_o;
    logic [2:0]        s_awsize_o;
    logic [1:0]        s_awburst_o;
    logic [2:0]        s_awid_o;
    logic              s_awvalid_o;
    logic              s_awready_i = 1'b0;
    logic [127:0]      s_wdata_o;
    logic              s_wvalid_o;
    logic              s_wlast_o;
    logic              s_wready_i = 1'b0;
    logic              s_bvalid_i = 1'b0;
    logic [2:0]        s_bid_i = '0;
    logic [1:0]        s_bresp_i = '0;
    logic              s_bready_o;

    upsizer_aw_arbiter #(
        .NUM_M(NM), .ADDR_WIDTH(32), .LEN_WIDTH(8), .ID_WIDTH(3),
        .DATA_WIDTH(128), .OUTSTANDING(OUT)
    ) dut (
        .aclk(aclk), .arst_n(arst_n),
        .m_awvalid_i(m_awvalid_i), .m_awaddr_i(m_awaddr_i), .m_awlen_i(m_awlen_i),
        .m_awsize_i(m_awsize_i), .m_awburst_i(m_awburst_i), .m_awid_i(m_awid_i),
        .m_awready_o(m_awready_o),
        .m_wdata_i(m_wdata_i), .m_wvalid_i(m_wvalid_i), .m_wlast_i(m_wlast_i),
        .m_wready_o(m_wready_o),
        .m_bvalid_o(m_bvalid_o), .m_bid_o(m_bid_o), .m_bresp_o(m_bresp_o),
        .m_bready_i(m_bready_i),
        .s_awaddr_o(s_awaddr_o), .s_awlen_o(s_awlen_o), .s_awsize_o(s_awsize_o),
        .s_awburst_o(s_awburst_o), .s_awid_o(s_awid_o),
        .s_awvalid_o(s_awvalid_o), .s_awready_i(s_awready_i),
        .s_wdata_o(s_wdata_o), .s_wvalid_o(s_wvalid_o), .s_wlast_o(s_wlast_o),
        .s_wready_i(s_wready_i),
        .s_bvalid_i(s_bvalid_i), .s_bid_i(s_bid_i), .s_bresp_i(s_bresp_i),
        .s_bready_o(s_bready_o)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // stimulus controls (written by the main sequence only)
    bit          stim_en = 0;
    bit          eager = 0;
    bit          fix_len = 0;
    bit          b_stall = 0;
    logic [NM-1:0] stim_mask = '1;

    // master/slave model state
    aw_t  aq [NM][$];
    aw_t  wq [NM][$];
    aw_t  exp_aw [NM][$];
    bit   hold_aw [NM];
    bit   hold_w [NM];
    int   wbeat [NM];
    logic [2:0] sl_ids [$];
    int   sl_done = 0;
    bit   hold_b = 0;

    // reference model state
    int   ptr = 0;
    bit   aw_active = 0;
    int   aw_w = 0;
    bit   owner_valid = 0;
    int   owner = 0;
    int   obeats = 0;
    aw_t  cur_aw;
    int   route_m [$];
    logic [2:0] route_id [$];
    bit   prev_idle = 1;
    logic [NM-1:0] prev_req = '0;
    int   prev_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mkdata(input int k, input logic [31:0] a, input int beat);
        return {a, 32'(k), 32'(beat), a ^ 32'hA5A5_5A5A};
    endfunction

    function automatic int rr_pick(input int p, input logic [NM-1:0] req);
        for (int i = 0; i < NM; i++) begin
            if (req[(p + i) % NM]) return (p + i) % NM;
        end
        return 0;
    endfunction

    // masters and slave: observe handshakes at negedge, drive just after posedge
    initial begin : stim
        aw_t e;
        forever begin
            @(negedge aclk);
            if (!arst_n) begin
                for (int k = 0; k < NM; k++) begin
                    aq[k].delete(); wq[k].delete(); exp_aw[k].delete();
                    hold_aw[k] = 0; hold_w[k] = 0; wbeat[k] = 0;
                end
                sl_ids.delete(); sl_done = 0; hold_b = 0;
            end else begin
                for (int k = 0; k < NM; k++) begin
                    if (m_awvalid_i[k] && m_awready_o[k]) begin
                        void'(aq[k].pop_front());
                        hold_aw[k] = 0;
                    end
                    if (m_wvalid_i[k] && m_wready_o[k]) begin
                        hold_w[k] = 0;
                        if (m_wlast_i[k]) begin
                            void'(wq[k].pop_front());
                            wbeat[k] = 0;
                        end else begin
                            wbeat[k]++;
                        end
                    end
                end
                if (s_awvalid_o && s_awready_i) sl_ids.push_back(s_awid_o);
                if (s_wvalid_o && s_wready_i && s_wlast_o) sl_done++;
                if (s_bvalid_i && s_bready_o) begin
                    void'(sl_ids.pop_front());
                    sl_done--;
                    hold_b = 0;
                end
            end
            @(posedge aclk);
            #1;
            if (!arst_n) begin
                m_awvalid_i = '0; m_wvalid_i = '0; m_wlast_i = '0; m_bready_i = '0;
                s_awready_i = 0; s_wready_i = 0; s_bvalid_i = 0;
            end else begin
                for (int k = 0; k < NM; k++) begin
                    if (stim_en && stim_mask[k] && aq[k].size() < 3 &&
                        (eager || $urandom_range(0, 3) == 0)) begin
                        e.addr  = $urandom;
                        e.len   = fix_len ? 8'd3 : 8'($urandom_range(0, 7));
                        e.size  = 3'($urandom);
                        e.burst = 2'($urandom);
                        e.id    = 3'($urandom);
                        aq[k].push_back(e);
                        wq[k].push_back(e);
                        exp_aw[k].push_back(e);
                    end
                    if (!hold_aw[k] && aq[k].size() > 0 && (eager || $urandom_range(0, 1) == 1))
                        hold_aw[k] = 1;
                    m_awvalid_i[k] = hold_aw[k];
                    if (hold_aw[k]) begin
                        m_awaddr_i[k*32 +: 32] = aq[k][0].addr;
                        m_awlen_i[k*8 +: 8]    = aq[k][0].len;
                        m_awsize_i[k*3 +: 3]   = aq[k][0].size;
                        m_awburst_i[k*2 +: 2]  = aq[k][0].burst;
                        m_awid_i[k*3 +: 3]     = aq[k][0].id;
                    end
                    if (!hold_w[k] && wq[k].size() > 0 && (eager || $urandom_range(0, 1) == 1))
                        hold_w[k] = 1;
                    m_wvalid_i[k] = hold_w[k];
                    if (hold_w[k]) begin
                        m_wdata_i[k*128 +: 128] = mkdata(k, wq[k][0].addr, wbeat[k]);
                        m_wlast_i[k] = (wbeat[k] == int'(wq[k][0].len));
                    end else begin
                        m_wlast_i[k] = 0;
                    end
                end
                s_awready_i = 1'($urandom);
                s_wready_i  = ($urandom_range(0, 3) != 0);
                m_bready_i  = NM'($urandom);
                if (!hold_b && !b_stall && sl_done > 0) begin
                    hold_b    = 1;
                    s_bid_i   = sl_ids[0];
                    s_bresp_i = 2'($urandom);
                end
                s_bvalid_i = hold_b;
            end
        end
    end

    // monitor: compares DUT outputs against the arbitration/routing model every cycle
    initial begin : monitor
        bit exp_start;
        logic [NM-1:0] ev;
        aw_t e;
        int h;
        forever begin
            @(negedge aclk);
            if (!arst_n) begin
                ptr = 0; aw_active = 0; owner_valid = 0; obeats = 0;
                route_m.delete(); route_id.delete();
                prev_idle = 1; prev_req = '0; prev_cnt = 0;
                continue;
            end
            exp_start = prev_idle && (prev_req != '0) && (prev_cnt < OUT);
            chk("s_awvalid", s_awvalid_o, aw_active || exp_start);
            if (exp_start) begin
                aw_active = 1;
                aw_w = rr_pick(ptr, prev_req);
            end
            if (aw_active) begin
                if (exp_aw[aw_w].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL aw_no_pending master=%0d t=%0t", aw_w, $time);
                end else begin
                    e = exp_aw[aw_w][0];
                    chk("s_awaddr", s_awaddr_o, e.addr);
                    chk("s_awlen", s_awlen_o, e.len);
                    chk("s_awsize", s_awsize_o, e.size);
                    chk("s_awburst", s_awburst_o, e.burst);
                    chk("s_awid", s_awid_o, e.id);
                end
                ev = s_awready_i ? (NM'(1) << aw_w) : '0;
                chk("m_awready", m_awready_o, ev);
            end else begin
                chk("m_awready_idle", m_awready_o, 0);
            end
            ev = owner_valid ? (NM'(s_wready_i) << owner) : '0;
            chk("m_wready", m_wready_o, ev);
            chk("s_wvalid", s_wvalid_o, owner_valid && m_wvalid_i[owner]);
            if (owner_valid && s_wvalid_o && s_wready_i) begin
                chk("s_wdata", s_wdata_o, mkdata(owner, cur_aw.addr, obeats));
                chk("s_wlast", s_wlast_o, obeats == int'(cur_aw.len));
            end
            if (route_m.size() > 0) begin
                h  = route_m[0];
                ev = s_bvalid_i ? (NM'(1) << h) : '0;
                chk("m_bvalid", m_bvalid_o, ev);
                chk("s_bready", s_bready_o, m_bready_i[h]);
                if (s_bvalid_i) begin
                    chk("m_bid", m_bid_o, route_id[0]);
                    chk("m_bresp", m_bresp_o, s_bresp_i);
                end
            end else begin
                chk("m_bvalid_empty", m_bvalid_o, 0);
                chk("s_bready_empty", s_bready_o, 0);
            end
            prev_idle = !aw_active && !owner_valid;
            prev_req  = m_awvalid_i;
            prev_cnt  = route_m.size();
            if (route_m.size() > 0 && s_bvalid_i && m_bready_i[route_m[0]]) begin
                void'(route_m.pop_front());
                void'(route_id.pop_front());
            end
            if (owner_valid && s_wvalid_o && s_wready_i) begin
                if (obeats == int'(cur_aw.len)) begin
                    owner_valid = 0;
                    ptr = (owner + 1) % NM;
                end else begin
                    obeats++;
                end
            end
            if (aw_active && s_awvalid_o && s_awready_i && exp_aw[aw_w].size() > 0) begin
                cur_aw = exp_aw[aw_w].pop_front();
                route_m.push_back(aw_w);
                route_id.push_back(cur_aw.id);
                aw_active   = 0;
                owner_valid = 1;
                owner       = aw_w;
                obeats      = 0;
            end
        end
    end

    function automatic bit all_idle();
        for (int k = 0; k < NM; k++) begin
            if (aq[k].size() != 0 || wq[k].size() != 0 || exp_aw[k].size() != 0) return 0;
        end
        return (sl_ids.size() == 0) && (route_m.size() == 0) && !aw_active && !owner_valid &&
               !s_bvalid_i;
    endfunction

    task automatic drain(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge aclk);
            #2;
            if (all_idle()) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_s_awvalid"}, s_awvalid_o, 0);
        chk({tag, "_s_wvalid"}, s_wvalid_o, 0);
        chk({tag, "_m_awready"}, m_awready_o, 0);
        chk({tag, "_m_wready"}, m_wready_o, 0);
        chk({tag, "_m_bvalid"}, m_bvalid_o, 0);
        chk({tag, "_s_bready"}, s_bready_o, 0);
    endtask

    initial begin : main
        bit found;
        arst_n = 0;
        repeat (3) @(negedge aclk);
        #2;
        chk_outputs_zero("reset");
        arst_n = 1;

        stim_en = 1;
        repeat (1500) @(negedge aclk);
        b_stall = 1;
        repeat (200) @(negedge aclk);
        b_stall = 0;
        repeat (200) @(negedge aclk);
        stim_en = 0;
        drain("drain_random");

        // reset in the middle of a 4-beat burst from master 0
        fix_len   = 1;
        stim_mask = 2'b01;
        stim_en   = 1;
        found     = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge aclk);
            #2;
            if (owner_valid && owner == 0 && obeats == 2) begin
                found = 1;
                break;
            end
        end
        chk("midburst_reached", found, 1);
        arst_n  = 0;
        stim_en = 0;
        #1;
        chk_outputs_zero("midburst_rst");
        repeat (3) @(negedge aclk);
        #2;
        fix_len   = 0;
        stim_mask = 2'b11;
        eager     = 1;
        stim_en   = 1;
        arst_n    = 1;
        repeat (300) @(negedge aclk);
        stim_en = 0;
        drain("drain_post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
